hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/flush/forward scheduler for the decode->execute pipeline register stage.
//  Tracks destination registers of in-flight instructions in E/M/W internally and detects RAW and load-use hazards.
//  Drives hold of PC and F/D register, bubble insertion into the D/E register, and operand-forward selects.
//  Sits beside the decode stage; consumes decoded fields, execute-stage branch outcome.
// PARAMETERS
//  NOP_OP     6'b110111  opcode injected into D/E register on bubble
//  BR_PENALTY 1          flush cycles after a taken branch (1..3)
//  CNT_W      16         width of stall-cycle counter
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rstd         in   1   synchronous active-low reset
//  id_valid     in   1   decode holds a real instruction
//  id_rs        in   5   source reg s
//  id_rt        in   5   source reg t
//  id_use_rs    in   1   instruction reads rs
//  id_use_rt    in   1   instruction reads rt
//  id_wreg      in   5   destination reg (0 = none)
//  id_is_load   in   1   instruction is a load
//  ex_br_taken  in   1   branch/jump in E resolved taken this cycle
//  stall_f      out  1   hold PC
//  stall_d      out  1   hold F/D register
//  bubble_e     out  1   D/E register loads NOP_OP, wreg 0
//  flush_d      out  1   F/D register cleared to NOP
//  fwd_s_sel    out  2   00 regfile, 01 E result, 10 M result, 11 W result
//  fwd_t_sel    out  2   same encoding for t operand
//  stall_cnt    out  CNT_W  saturating count of stall+flush cycles
// BEHAVIOUR
//  Reset (rstd=0 at edge): state RUN, dst_e/dst_m/dst_w=0, ld_e=0, flush count 0, stall_cnt=0.
//  While rstd=0 outputs forced: bubble_e=1, flush_d=1, stall_f=stall_d=0, fwd_*=00.
//  Scoreboard each edge: dst_w<=dst_m; dst_m<=dst_e; dst_e<=(bubble_e|!id_valid)?0:id_wreg; ld_e likewise.
//  Match(src,d) = use && src!=0 && src==d. Reg 0 never hazards/forwards.
//  States: RUN, LDSTALL, FLUSH.
//   RUN: ex_br_taken -> FLUSH (cnt=BR_PENALTY-1); else load-use (Match vs dst_e && ld_e) -> LDSTALL.
//   LDSTALL: exactly 1 cycle; stall_f=stall_d=bubble_e=1; -> RUN (load now in M, forwarded via 10).
//   FLUSH: flush_d=bubble_e=1, stall=0; count down, -> RUN at 0. BR_PENALTY=1 means flush only on the taken cycle.
//  Outputs combinational from state+inputs (same cycle as hazard visible); stall_cnt registered.
//  Priority: ex_br_taken > load-use stall > forwarding. Taken branch during LDSTALL aborts the stall.
//  Forward priority per operand: E > M > W (youngest wins); E source illegal when ld_e (stall covers it).
//  stall_cnt +1 on every cycle with stall_d|flush_d; saturates at all-ones, no wrap.
//  Reset mid-FLUSH or mid-LDSTALL: state returns to RUN on that edge, no residual bubbles.
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding active as above; only load-use stalls.
//  Not defined: fwd_*_sel tied 00; any Match vs dst_e/dst_m/dst_w stalls (stall_f=stall_d=bubble_e=1)
//   in RUN until cleared; regfile is not write-bypassing, so W match also stalls; LDSTALL unused.
// STRUCTURE
//  Package pipe_pkg: NOP_OP, fwd-select encodings (FWD_RF/E/M/W), state enum, REG_W=5.
//  Sub-module hazard_scoreboard: dst_e/m/w + ld_e shift chain with bubble insertion, Match outputs.
// TESTING
//  lw $3 then add $4,$3,$5 -> one cycle stall_d=bubble_e=1, next cycle fwd_s_sel=10, stall_cnt=1.
//  add $3 then sub $6,$3,$3 (FWD_EN) -> no stall, fwd_s_sel=fwd_t_sel=01.
//  ex_br_taken with BR_PENALTY=2 -> flush_d=bubble_e=1 for 2 cycles, stall_cnt+=2.
//  Load-use and ex_br_taken same cycle -> flush only, no LDSTALL entered.
//  Writes to $0 then read $0 -> fwd 00, no stall; rstd low mid-FLUSH -> RUN, bubble_e=1 only while in reset.
//  Without HAZARD_FWD_EN: add $3; use $3 next -> stall 3 cycles until dst_w clears; stall_cnt saturates at 2^CNT_W-1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute hazard controller.
// The NOP opcode, forward-select encodings, FSM states and the operand match helper live here.
package pipe_pkg;

    localparam int         REG_W  = 5;
    localparam logic [5:0] NOP_OP = 6'b110111;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_E  = 2'b01,
        FWD_M  = 2'b10,
        FWD_W  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDSTALL,
        ST_FLUSH
    } hz_state_e;

    // Per-operand hits against each in-flight destination
    typedef struct packed {
        logic s_e, s_m, s_w;
        logic t_e, t_m, t_w;
    } hz_match_t;

    // Register 0 is hardwired, so it never creates a dependency
    function automatic logic reg_match(input logic rd, input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return rd && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination-register shift chain for the E/M/W stages plus the load flag of E.
// Bubbled or empty decode slots enter the chain as register 0 so they never match.
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rstd,
    input  logic             id_valid,
    input  logic             bubble,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_is_load,
    output hz_match_t        match,
    output logic             ld_e
);

    logic [REG_W-1:0] dst_e, dst_m, dst_w;

    always_ff @(posedge clk) begin
        if (!rstd) begin
            dst_e <= '0;
            dst_m <= '0;
            dst_w <= '0;
            ld_e  <= 1'b0;
        end else begin
            dst_w <= dst_m;
            dst_m <= dst_e;
            if (bubble || !id_valid) begin
                dst_e <= '0;
                ld_e  <= 1'b0;
            end else begin
                dst_e <= id_wreg;
                ld_e  <= id_is_load;
            end
        end
    end

    always_comb begin
        match.s_e = reg_match(id_valid && id_use_rs, id_rs, dst_e);
        match.s_m = reg_match(id_valid && id_use_rs, id_rs, dst_m);
        match.s_w = reg_match(id_valid && id_use_rs, id_rs, dst_w);
        match.t_e = reg_match(id_valid && id_use_rt, id_rt, dst_e);
        match.t_m = reg_match(id_valid && id_use_rt, id_rt, dst_m);
        match.t_w = reg_match(id_valid && id_use_rt, id_rt, dst_w);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward scheduler for the decode->execute register stage.
// HAZARD_FWD_EN enables operand forwarding; without it every RAW match stalls until the writer retires.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_is_load,
    input  logic             ex_br_taken,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_e,
    output logic             flush_d,
    output logic [1:0]       fwd_s_sel,
    output logic [1:0]       fwd_t_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_e state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;
    hz_match_t  match;
    logic       ld_e;
    logic       hazard;
    fwd_sel_e   fs, ft;

    hazard_scoreboard u_sb (
        .clk        (clk),
        .rstd       (rstd),
        .id_valid   (id_valid),
        .bubble     (bubble_e),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wreg    (id_wreg),
        .id_is_load (id_is_load),
        .match      (match),
        .ld_e       (ld_e)
    );

    always_ff @(posedge clk) begin
        if (!rstd) begin
            state <= ST_RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        fs = FWD_RF;
        ft = FWD_RF;
`ifdef HAZARD_FWD_EN
        // Youngest producer wins; a load still in E has no result yet
        if (match.s_e && !ld_e) fs = FWD_E;
        else if (match.s_m)     fs = FWD_M;
        else if (match.s_w)     fs = FWD_W;
        if (match.t_e && !ld_e) ft = FWD_E;
        else if (match.t_m)     ft = FWD_M;
        else if (match.t_w)     ft = FWD_W;
        hazard = ld_e && (match.s_e || match.t_e);
`else
        hazard = |match;
`endif
    end

    // The stall bubble is issued on the cycle the hazard is seen; LDSTALL marks the load moving to M
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        bubble_e  = 1'b0;
        flush_d   = 1'b0;
        fwd_s_sel = fs;
        fwd_t_sel = ft;
        if (ex_br_taken) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
            if (BR_PENALTY > 1) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = 2'(BR_PENALTY - 1);
            end else begin
                state_nxt = ST_RUN;
            end
        end else begin
            case (state)
                ST_FLUSH: begin
                    flush_d  = 1'b1;
                    bubble_e = 1'b1;
                    if (fcnt <= 2'd1) state_nxt = ST_RUN;
                    else              fcnt_nxt  = fcnt - 2'd1;
                end
                default: begin
                    state_nxt = ST_RUN;
                    if (hazard) begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        bubble_e = 1'b1;
`ifdef HAZARD_FWD_EN
                        state_nxt = ST_LDSTALL;
`endif
                    end
                end
            endcase
        end
        if (!rstd) begin
            stall_f   = 1'b0;
            stall_d   = 1'b0;
            bubble_e  = 1'b1;
            flush_d   = 1'b1;
            fwd_s_sel = FWD_RF;
            fwd_t_sel = FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstd)
            stall_cnt <= '0;
        else if ((stall_d || flush_d) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations, a negedge monitor compares.
// Expectations cover both the forwarding and the stall-only build.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int BRP   = 2;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
    localparam int C   = 1;
`else
    localparam bit FWD = 1'b0;
    localparam int C   = 6;
`endif

    logic clk = 1'b0;
    logic rstd = 1'b0;
    logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_is_load = 1'b0, ex_br_taken = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;
    logic stall_f, stall_d, bubble_e, flush_d;
    logic [1:0] fwd_s_sel, fwd_t_sel;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.BR_PENALTY(BRP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstd(rstd), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_is_load(id_is_load),
        .ex_br_taken(ex_br_taken), .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e),
        .flush_d(flush_d), .fwd_s_sel(fwd_s_sel), .fwd_t_sel(fwd_t_sel), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic sf, sd, be, fd;
        logic [1:0] fs, ft;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } ent_t;

    ent_t q[$];
    int total = 0;
    int bad = 0;

    function automatic exp_t ex(input logic sf, sd, be, fd, input logic [1:0] fs, ft, input int cnt);
        exp_t r;
        r.sf = sf; r.sd = sd; r.be = be; r.fd = fd; r.fs = fs; r.ft = ft; r.cnt = CNT_W'(cnt);
        return r;
    endfunction
    function automatic exp_t zr(input int c); return ex(0, 0, 0, 0, 2'd0, 2'd0, c); endfunction
    function automatic exp_t st(input int c); return ex(1, 1, 1, 0, 2'd0, 2'd0, c); endfunction
    function automatic exp_t fl(input int c); return ex(0, 0, 1, 1, 2'd0, 2'd0, c); endfunction

    task automatic step(input string nm, input logic r, v, input logic [4:0] rs, rt,
                        input logic urs, urt, input logic [4:0] wr, input logic ld, br, input exp_t e);
        ent_t t;
        @(posedge clk);
        #1;
        rstd = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr; id_is_load = ld; ex_br_taken = br;
        t.e = e;
        t.name = nm;
        q.push_back(t);
    endtask

    task automatic nop(input string nm, input logic r, br, input exp_t e);
        step(nm, r, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, e);
    endtask

    ent_t mt;
    exp_t act;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mt  = q.pop_front();
            act = {stall_f, stall_d, bubble_e, flush_d, fwd_s_sel, fwd_t_sel, stall_cnt};
            total++;
            if (act !== mt.e) begin
                bad++;
                $display("FAIL %s: got sf=%b sd=%b be=%b fd=%b fs=%b ft=%b cnt=%0d, want sf=%b sd=%b be=%b fd=%b fs=%b ft=%b cnt=%0d",
                         mt.name, act.sf, act.sd, act.be, act.fd, act.fs, act.ft, act.cnt,
                         mt.e.sf, mt.e.sd, mt.e.be, mt.e.fd, mt.e.fs, mt.e.ft, mt.e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        nop("reset0", 0, 0, fl(0));
        nop("reset1", 0, 0, fl(0));
        // lw $3 ; add $4,$3,$5
        step("lw3",      1, 1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0, zr(0));
        step("ldu_stall",1, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0, 0, st(0));
        step("ldu_fwdM", 1, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0, 0, FWD ? ex(0,0,0,0,2'b10,2'b00,1) : st(1));
        step("ldu_fwdW", 1, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0, 0, FWD ? ex(0,0,0,0,2'b11,2'b00,1) : st(2));
        for (int i = 0; i < 3; i++) nop("drain_a", 1, 0, zr(FWD ? 1 : 3));
        // add $3 ; sub $6,$3,$3
        step("add3",     1, 1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, zr(FWD ? 1 : 3));
        step("raw_e",    1, 1, 5'd3, 5'd3, 1, 1, 5'd6, 0, 0, FWD ? ex(0,0,0,0,2'b01,2'b01,1) : st(3));
        step("raw_m",    1, 1, 5'd3, 5'd3, 1, 1, 5'd6, 0, 0, FWD ? ex(0,0,0,0,2'b10,2'b10,1) : st(4));
        step("raw_w",    1, 1, 5'd3, 5'd3, 1, 1, 5'd6, 0, 0, FWD ? ex(0,0,0,0,2'b11,2'b11,1) : st(5));
        step("raw_clr",  1, 1, 5'd3, 5'd3, 1, 1, 5'd6, 0, 0, zr(C));
        for (int i = 0; i < 3; i++) nop("drain_b", 1, 0, zr(C));
        // register 0 never hazards
        step("lw0",      1, 1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, zr(C));
        step("read0",    1, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, zr(C));
        // taken branch, penalty 2; flushed slot must not enter the scoreboard
        step("br_take",  1, 1, 5'd0, 5'd0, 0, 0, 5'd5, 0, 1, fl(C));
        step("br_flush", 1, 1, 5'd0, 5'd0, 0, 0, 5'd5, 0, 0, fl(C + 1));
        step("br_done",  1, 1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, zr(C + 2));
        // load-use coincident with taken branch
        step("lw3_b",    1, 1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0, zr(C + 2));
        step("ldu_br",   1, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0, 1, fl(C + 2));
        nop("ldu_br_fl", 1, 0, fl(C + 3));
        nop("ldu_br_run",1, 0, zr(C + 4));
        nop("drain_c",   1, 0, zr(C + 4));
        // reset in the middle of a flush
        nop("br_take2",  1, 1, fl(C + 4));
        nop("rst_mid",   0, 0, fl(C + 5));
        nop("rst_out",   1, 0, zr(0));
        // counter saturation
        for (int i = 0; i < 17; i++) nop("sat", 1, 1, fl(i > 15 ? 15 : i));
        nop("sat_flush", 1, 0, fl(15));
        nop("sat_run",   1, 0, zr(15));
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
